// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback port arbiter: default widths and requester indices.
package wb_port_arbiter_pkg;
    localparam int WB_DW      = 32;
    localparam int WB_AW      = 5;
    localparam int WB_NUM_SRC = 3;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational rotating-priority picker: the search starts at ptr+1 and wraps.
// A constant ptr of NUM_SRC-1 turns it into a lowest-index-first picker.
module wb_rr_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_vld
);
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            j = (int'(ptr) + k) % NUM_SRC;
            if (!gnt_vld && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port among NUM_SRC writeback requesters, with a
// registered output and a saturating contention counter. Define WB_ARB_RR_EN for round-robin.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int DW      = WB_DW,
    parameter int AW      = WB_AW,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic [NUM_SRC*AW-1:0] src_waddr,
    input  logic [NUM_SRC*DW-1:0] src_wdata,
    output logic                  wb_ena,
    output logic [AW-1:0]         wb_waddr,
    output logic [DW-1:0]         wb_wdata,
    output logic [CNT_W-1:0]      conflict_cnt
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NUM_SRC-1:0] null_req;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      ptr;
    logic               gnt_vld;
    logic               contention;

    logic               wb_ena_q,   wb_ena_d;
    logic [AW-1:0]      wb_waddr_q, wb_waddr_d;
    logic [DW-1:0]      wb_wdata_q, wb_wdata_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    // Writes to r0 are acknowledged at once and never compete for the port.
    always_comb begin
        null_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            null_req[i] = src_valid[i] && (src_waddr[i*AW +: AW] == '0);
        end
    end

    assign cand       = src_valid & ~null_req;
    assign contention = |(cand & (cand - NUM_SRC'(1)));

    wb_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_arb (
        .req     (cand),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign src_ready = gnt | null_req;

`ifdef WB_ARB_RR_EN
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= IW'(NUM_SRC - 1);
        end else if (gnt_vld) begin
            ptr_q <= gnt_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = IW'(NUM_SRC - 1);
`endif

    always_comb begin
        wb_ena_d   = gnt_vld;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        cnt_d      = contention ? sat_inc(cnt_q) : cnt_q;
        if (gnt_vld) begin
            wb_waddr_d = src_waddr[int'(gnt_idx)*AW +: AW];
            wb_wdata_d = src_wdata[int'(gnt_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_ena_q   <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            wb_ena_q   <= wb_ena_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_ena       = wb_ena_q;
    assign wb_waddr     = wb_waddr_q;
    assign wb_wdata     = wb_wdata_q;
    assign conflict_cnt = cnt_q;
endmodule
